// File: rtl/clkcounter_monitor.sv
// Frequency monitor: judges each per-second tick count against a nominal window,
// tracks lock/fault state, min/max statistics and a saturating sample count.
module clkcounter_monitor #(
  parameter int unsigned     BUSW      = 32,
  parameter longint unsigned NOMINAL   = 100_000_000,
  parameter longint unsigned TOLERANCE = 100_000,
  parameter int unsigned     LOCK_CNT  = 4,
  parameter int unsigned     NSAMPW    = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_pps,
  input  logic [BUSW-1:0]   i_counts,
  input  logic              i_clear,
  output logic              o_valid,
  output logic [BUSW-1:0]   o_last,
  output logic [BUSW-1:0]   o_min,
  output logic [BUSW-1:0]   o_max,
  output logic [1:0]        o_state,
  output logic              o_locked,
  output logic              o_stopped,
  output logic              o_fault,
  output logic [NSAMPW-1:0] o_nsamples,
  output logic              o_int
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_FAULT   = 2'd3
  } state_e;

  localparam int unsigned GOODW = $clog2(LOCK_CNT + 1);

  // Window bounds saturate at the ends of the BUSW-bit range (BUSW < 64 assumed).
  localparam longint unsigned MAX_COUNT = (64'd1 << BUSW) - 64'd1;
  localparam logic [BUSW-1:0] LO = (NOMINAL > TOLERANCE) ? BUSW'(NOMINAL - TOLERANCE) : '0;
  localparam logic [BUSW-1:0] HI = ((NOMINAL + TOLERANCE) > MAX_COUNT) ?
                                   BUSW'(MAX_COUNT) : BUSW'(NOMINAL + TOLERANCE);

  logic              pps_q;
  state_e            state_q,   state_d;
  logic [GOODW-1:0]  good_q,    good_d;
  logic              valid_q,   valid_d;
  logic [BUSW-1:0]   last_q,    last_d;
  logic [BUSW-1:0]   min_q,     min_d;
  logic [BUSW-1:0]   max_q,     max_d;
  logic              stopped_q, stopped_d;
  logic              fault_q,   fault_d;
  logic [NSAMPW-1:0] nsamp_q,   nsamp_d;
  logic              int_q,     int_d;

  logic             in_range;
  logic             eval;
  logic             fault_set;
  logic [GOODW-1:0] good_inc;

  // The counter output settles on the PPS edge, so counts are read one cycle later.
  assign in_range = (i_counts >= LO) && (i_counts <= HI);
  assign eval     = pps_q && (state_q != ST_IDLE);
  assign good_inc = good_q + GOODW'(1);

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d   = state_q;
    good_d    = good_q;
    valid_d   = 1'b0;
    last_d    = last_q;
    min_d     = min_q;
    max_d     = max_q;
    stopped_d = stopped_q;
    fault_d   = fault_q;
    nsamp_d   = nsamp_q;
    int_d     = 1'b0;
    fault_set = 1'b0;

    if (pps_q) begin
      unique case (state_q)
        ST_IDLE: state_d = ST_ACQUIRE;
        ST_ACQUIRE: begin
          if (in_range) begin
            good_d = good_inc;
            if (good_inc == GOODW'(LOCK_CNT)) begin
              state_d = ST_LOCKED;
              int_d   = 1'b1;
            end
          end else begin
            good_d = '0;
          end
        end
        ST_LOCKED: begin
          if (!in_range) begin
            state_d   = ST_FAULT;
            fault_set = 1'b1;
            int_d     = 1'b1;
            good_d    = '0;
          end
        end
        ST_FAULT: begin
          if (in_range) begin
            state_d = ST_ACQUIRE;
            good_d  = GOODW'(1);
          end else begin
            good_d = '0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (i_clear) begin
      fault_d = 1'b0;
      min_d   = '1;
      max_d   = '0;
      nsamp_d = '0;
    end

    if (eval) begin
      valid_d   = 1'b1;
      last_d    = i_counts;
      stopped_d = (i_counts == '0);
      // A clear landing with a sample restarts the statistics from that sample.
      if (i_clear) begin
        min_d   = i_counts;
        max_d   = i_counts;
        nsamp_d = NSAMPW'(1);
      end else begin
        min_d   = (i_counts < min_q) ? i_counts : min_q;
        max_d   = (i_counts > max_q) ? i_counts : max_q;
        nsamp_d = (&nsamp_q) ? nsamp_q : nsamp_q + NSAMPW'(1);
      end
    end

    if (fault_set) fault_d = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (i_reset) begin
      pps_q     <= 1'b0;
      state_q   <= ST_IDLE;
      good_q    <= '0;
      valid_q   <= 1'b0;
      last_q    <= '0;
      min_q     <= '1;
      max_q     <= '0;
      stopped_q <= 1'b0;
      fault_q   <= 1'b0;
      nsamp_q   <= '0;
      int_q     <= 1'b0;
    end else begin
      pps_q     <= i_pps;
      state_q   <= state_d;
      good_q    <= good_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      min_q     <= min_d;
      max_q     <= max_d;
      stopped_q <= stopped_d;
      fault_q   <= fault_d;
      nsamp_q   <= nsamp_d;
      int_q     <= int_d;
    end
  end

  assign o_valid    = valid_q;
  assign o_last     = last_q;
  assign o_min      = min_q;
  assign o_max      = max_q;
  assign o_state    = state_q;
  assign o_locked   = (state_q == ST_LOCKED);
  assign o_stopped  = stopped_q;
  assign o_fault    = fault_q;
  assign o_nsamples = nsamp_q;
  assign o_int      = int_q;

endmodule

// File: tb/tb_clkcounter_monitor.sv
// Scoreboard bench for clkcounter_monitor: a run-length reference model predicts
// every evaluated sample; a monitor compares whenever o_valid rises.
module tb_clkcounter_monitor;

  localparam int unsigned     BUSW = 32;
  localparam longint unsigned NOM  = 1000;
  localparam longint unsigned TOL  = 10;
  localparam int unsigned     LOCK = 3;
  localparam longint unsigned LO_M = NOM - TOL;
  localparam longint unsigned HI_M = NOM + TOL;

  logic            clk = 1'b0;
  logic            rst;
  logic            pps;
  logic            clr;
  logic [BUSW-1:0] cnt;

  logic            o_valid, o_locked, o_stopped, o_fault, o_int;
  logic [BUSW-1:0] o_last, o_min, o_max;
  logic [1:0]      o_state;
  logic [15:0]     o_nsamples;

  logic            b_valid, b_locked, b_stopped, b_fault, b_int;
  logic [BUSW-1:0] b_last, b_min, b_max;
  logic [1:0]      b_state;
  logic [1:0]      b_nsamples;

  always #5 clk = ~clk;

  clkcounter_monitor #(.BUSW(BUSW), .NOMINAL(NOM), .TOLERANCE(TOL), .LOCK_CNT(LOCK), .NSAMPW(16)) dut (
    .i_clk(clk), .i_reset(rst), .i_pps(pps), .i_counts(cnt), .i_clear(clr),
    .o_valid(o_valid), .o_last(o_last), .o_min(o_min), .o_max(o_max), .o_state(o_state),
    .o_locked(o_locked), .o_stopped(o_stopped), .o_fault(o_fault), .o_nsamples(o_nsamples),
    .o_int(o_int)
  );

  clkcounter_monitor #(.BUSW(BUSW), .NOMINAL(NOM), .TOLERANCE(TOL), .LOCK_CNT(LOCK), .NSAMPW(2)) dut_small (
    .i_clk(clk), .i_reset(rst), .i_pps(pps), .i_counts(cnt), .i_clear(clr),
    .o_valid(b_valid), .o_last(b_last), .o_min(b_min), .o_max(b_max), .o_state(b_state),
    .o_locked(b_locked), .o_stopped(b_stopped), .o_fault(b_fault), .o_nsamples(b_nsamples),
    .o_int(b_int)
  );

  typedef struct {
    logic [31:0] last, mn, mx;
    logic [1:0]  state;
    logic        stopped, fault, intr;
    logic [15:0] n16;
    logic [1:0]  n2;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, want, $time);
    end
  endtask

  // Reference model: lock is a run of LOCK consecutive in-range samples while unlocked.
  int          m_st;
  int          m_run;
  longint      m_n;
  logic [31:0] m_min, m_max;
  logic        m_fault;

  task automatic model_reset();
    m_st = 0; m_run = 0; m_n = 0; m_min = '1; m_max = '0; m_fault = 1'b0;
  endtask

  task automatic model_clear();
    m_fault = 1'b0; m_min = '1; m_max = '0; m_n = 0;
  endtask

  task automatic model_sample(input logic [31:0] v, input bit c);
    exp_t e;
    bit   inr, fset, intr;
    if (m_st == 0) begin
      m_st = 1;
      if (c) model_clear();
      return;
    end
    inr  = (longint'(v) >= LO_M) && (longint'(v) <= HI_M);
    fset = 1'b0;
    intr = 1'b0;
    if (m_st == 2) begin
      if (!inr) begin m_st = 3; fset = 1'b1; intr = 1'b1; m_run = 0; end
    end else if (inr) begin
      m_run++;
      if (m_run >= LOCK) begin m_st = 2; intr = 1'b1; end
      else m_st = 1;
    end else begin
      m_run = 0;
    end
    if (c) begin
      m_min = v; m_max = v; m_n = 1; m_fault = 1'b0;
    end else begin
      if (v < m_min) m_min = v;
      if (v > m_max) m_max = v;
      m_n++;
    end
    if (fset) m_fault = 1'b1;
    e.last = v; e.mn = m_min; e.mx = m_max; e.state = 2'(m_st);
    e.stopped = (v == 0); e.fault = m_fault; e.intr = intr;
    e.n16 = (m_n > 65535) ? 16'hFFFF : 16'(m_n);
    e.n2  = (m_n > 3) ? 2'd3 : 2'(m_n);
    q.push_back(e);
  endtask

  // Monitor: pops one expectation per o_valid, otherwise o_int must stay low.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      check("valid_small", 64'(b_valid), 64'(o_valid));
      if (o_valid === 1'b1) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got o_valid=1, want no sample pending at %0t", $time);
        end else begin
          e = q.pop_front();
          check("last",     64'(o_last),     64'(e.last));
          check("min",      64'(o_min),      64'(e.mn));
          check("max",      64'(o_max),      64'(e.mx));
          check("state",    64'(o_state),    64'(e.state));
          check("locked",   64'(o_locked),   64'(e.state == 2'd2));
          check("stopped",  64'(o_stopped),  64'(e.stopped));
          check("fault",    64'(o_fault),    64'(e.fault));
          check("int",      64'(o_int),      64'(e.intr));
          check("nsamples", 64'(o_nsamples), 64'(e.n16));
          check("nsamp_sat",64'(b_nsamples), 64'(e.n2));
        end
      end else begin
        check("int_quiet", 64'(o_int), 64'd0);
      end
    end
  end

  // Samples: pps in the first cycle, then one count per cycle with pps overlapping.
  task automatic burst(input logic [31:0] vals[$], input bit clrs[$]);
    @(posedge clk); #1 pps = 1'b1;
    for (int i = 0; i < vals.size(); i++) begin
      @(posedge clk); #1;
      pps = (i < vals.size() - 1);
      cnt = vals[i];
      clr = clrs[i];
      model_sample(vals[i], clrs[i]);
    end
    @(posedge clk); #1 clr = 1'b0;
  endtask

  task automatic send(input logic [31:0] v, input bit c = 1'b0);
    logic [31:0] vs[$];
    bit          cs[$];
    vs.push_back(v);
    cs.push_back(c);
    burst(vs, cs);
  endtask

  task automatic pulse_clear();
    @(posedge clk); #1 clr = 1'b1;
    model_clear();
    @(posedge clk); #1 clr = 1'b0;
  endtask

  task automatic drain();
    repeat (4) @(posedge clk);
    #1 check("drain_pending", 64'(q.size()), 64'd0);
  endtask

  task automatic check_reset_values();
    check("rst_valid",    64'(o_valid),    64'd0);
    check("rst_last",     64'(o_last),     64'd0);
    check("rst_min",      64'(o_min),      64'hFFFF_FFFF);
    check("rst_max",      64'(o_max),      64'd0);
    check("rst_state",    64'(o_state),    64'd0);
    check("rst_locked",   64'(o_locked),   64'd0);
    check("rst_stopped",  64'(o_stopped),  64'd0);
    check("rst_fault",    64'(o_fault),    64'd0);
    check("rst_nsamples", 64'(o_nsamples), 64'd0);
    check("rst_int",      64'(o_int),      64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] vs[$];
    bit          cs[$];
    rst = 1'b1; pps = 1'b0; clr = 1'b0; cnt = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_values();

    // Discarded power-on sample, then lock on the third evaluated sample.
    send(32'hDEADBEF0);
    send(1000); send(995); send(1010);
    drain();
    check("t1_state", 64'(o_state), 64'd2);
    check("t1_min",   64'(o_min),   64'd995);
    check("t1_max",   64'(o_max),   64'd1010);
    check("t1_n",     64'(o_nsamples), 64'd3);

    // Loss of lock, then back-to-back recovery; fault stays sticky until clear.
    vs = '{1011, 1000, 1000, 1000}; cs = '{0, 0, 0, 0};
    burst(vs, cs);
    drain();
    check("t2_fault_sticky", 64'(o_fault), 64'd1);
    pulse_clear();
    #1 check("t2_fault_clr", 64'(o_fault), 64'd0);
    check("t2_min_clr", 64'(o_min), 64'hFFFF_FFFF);

    // Reacquire with an out-of-range sample and both window boundaries.
    send(1011);
    vs = '{1000, 989, 990, 1010, 1000}; cs = '{0, 0, 0, 0, 0};
    burst(vs, cs);
    drain();

    // Stopped clock, then recovery.
    send(0); send(1000);
    drain();
    send(1000); send(1000);
    // Faulting sample coincides with clear: stats restart, fault wins.
    send(1011, 1'b1);
    drain();
    check("t5_fault", 64'(o_fault), 64'd1);
    check("t5_n",     64'(o_nsamples), 64'd1);
    send(1005, 1'b1);

    // Randomized bursts.
    for (int b = 0; b < 40; b++) begin
      int len;
      vs = {}; cs = {};
      len = $urandom_range(1, 4);
      for (int i = 0; i < len; i++) begin
        int sel;
        logic [31:0] v;
        sel = $urandom_range(0, 9);
        if (sel <= 5)      v = 32'($urandom_range(990, 1010));
        else if (sel == 6) v = ($urandom_range(0, 1) != 0) ? 32'd989 : 32'd1011;
        else if (sel == 7) v = 32'd0;
        else if (sel == 8) v = $urandom;
        else               v = ($urandom_range(0, 1) != 0) ? 32'd990 : 32'd1010;
        vs.push_back(v);
        cs.push_back($urandom_range(0, 9) == 0);
      end
      burst(vs, cs);
      if ($urandom_range(0, 7) == 0) pulse_clear();
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    drain();

    // Reset lands between pps and the evaluated sample: the sample is dropped.
    @(posedge clk); #1 pps = 1'b1;
    @(posedge clk); #1 pps = 1'b0; rst = 1'b1; cnt = 1000;
    @(posedge clk); #1 rst = 1'b0;
    model_reset();
    check_reset_values();
    send(1000);
    drain();
    check("post_rst_discard_n", 64'(o_nsamples), 64'd0);
    vs = '{1000, 1000, 1000, 1000, 1000, 1000}; cs = '{0, 0, 0, 0, 0, 0};
    burst(vs, cs);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
